// File: rtl/sys_bus_interconnect.sv
// sys_bus_interconnect
// Routes one system-bus read or write at a time to one of NUM_SLV peripheral
// register banks, selected by addr[SLV_SHIFT +: log2(NUM_SLV)]. The response
// (rdata/err/ack) is registered. Unpopulated slaves get an immediate error.
// Silent slaves get an error after TIMEOUT cycles. This timeout is shorter
// than the 32-cycle timeout of the upstream bridge.
//
// Ports
//   clk_i, rstn_i        clock, async active-low reset
//   sys_*_i / sys_*_o    upstream request strobes and registered response
//   slv_addr_o           captured address with slave-index and upper bits cleared
//   slv_wdata_o/sel_o    captured write data / byte select (held until next capture)
//   slv_wen_o/ren_o      one-hot, single-cycle strobes toward the selected slave
//   slv_rdata_i/err_i/ack_i  per-slave response inputs (slave n data in [n*SYS_DW +: SYS_DW])
module sys_bus_interconnect #(
    parameter int                SYS_AW    = 32,
    parameter int                SYS_DW    = 32,
    parameter int                SYS_SW    = SYS_DW / 8,
    parameter int                NUM_SLV   = 8,
    parameter int                SLV_SHIFT = 20,
    parameter logic [NUM_SLV-1:0] SLV_EN   = {NUM_SLV{1'b1}},
    parameter int                TIMEOUT   = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [SYS_AW-1:0]         sys_addr_i,
    input  logic [SYS_DW-1:0]         sys_wdata_i,
    input  logic [SYS_SW-1:0]         sys_sel_i,
    input  logic                      sys_wen_i,
    input  logic                      sys_ren_i,
    output logic [SYS_DW-1:0]         sys_rdata_o,
    output logic                      sys_err_o,
    output logic                      sys_ack_o,
    output logic [SYS_AW-1:0]         slv_addr_o,
    output logic [SYS_DW-1:0]         slv_wdata_o,
    output logic [SYS_SW-1:0]         slv_sel_o,
    output logic [NUM_SLV-1:0]        slv_wen_o,
    output logic [NUM_SLV-1:0]        slv_ren_o,
    input  logic [NUM_SLV*SYS_DW-1:0] slv_rdata_i,
    input  logic [NUM_SLV-1:0]        slv_err_i,
    input  logic [NUM_SLV-1:0]        slv_ack_i
);

    localparam int IW = $clog2(NUM_SLV);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [SYS_AW-1:0] OFF_MASK = (SYS_AW'(1) << SLV_SHIFT) - SYS_AW'(1);
    // Timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [4:0]        TO_LAST  = 5'(TIMEOUT - 1);

    logic [0:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [SYS_AW-1:0]  addr_q, addr_d;
    logic [SYS_DW-1:0]  wdata_q, wdata_d;
    logic [SYS_SW-1:0]  sel_q, sel_d;
    logic [NUM_SLV-1:0] wen_q, wen_d;
    logic [NUM_SLV-1:0] ren_q, ren_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [SYS_DW-1:0]  rdata_q, rdata_d;

    logic               req;
    logic [IW-1:0]      req_idx;
    logic               sel_ack;
    logic               sel_err;
    logic [SYS_DW-1:0]  sel_rdata;

    assign req     = sys_wen_i | sys_ren_i;
    assign req_idx = sys_addr_i[SLV_SHIFT +: IW];
    assign sel_ack = slv_ack_i[idx_q];
    assign sel_err = slv_err_i[idx_q];

    always_comb begin
        sel_rdata = '0;
        for (int n = 0; n < NUM_SLV; n++) begin
            if (IW'(n) == idx_q) begin
                sel_rdata = slv_rdata_i[n*SYS_DW +: SYS_DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        wen_d   = '0;
        ren_d   = '0;
        ack_d   = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = sys_addr_i & OFF_MASK;
                    wdata_d = sys_wdata_i;
                    sel_d   = sys_sel_i;
                    idx_d   = req_idx;
                    wr_d    = sys_wen_i;   // write wins when both strobes are set
                    cnt_d   = '0;
                    if (SLV_EN[req_idx]) begin
                        state_d = S_BUSY;
                        if (sys_wen_i) begin
                            wen_d = NUM_SLV'(1) << req_idx;
                        end else begin
                            ren_d = NUM_SLV'(1) << req_idx;
                        end
                    end else begin
                        // Unpopulated slot: answer on the capture edge itself.
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_BUSY: begin
                if (sel_ack) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    err_d   = sel_err;
                    rdata_d = wr_q ? '0 : sel_rdata;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = cnt_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            wen_q   <= '0;
            ren_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign sys_rdata_o = rdata_q;
    assign sys_err_o   = err_q;
    assign sys_ack_o   = ack_q;
    assign slv_addr_o  = addr_q;
    assign slv_wdata_o = wdata_q;
    assign slv_sel_o   = sel_q;
    assign slv_wen_o   = wen_q;
    assign slv_ren_o   = ren_q;

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Directed, table-driven bench for sys_bus_interconnect (SLV_EN=0x7F, TIMEOUT=16).
module tb_sys_bus_interconnect;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [31:0]  sys_addr = '0;
    logic [31:0]  sys_wdata = '0;
    logic [3:0]   sys_sel = '0;
    logic         sys_wen = 1'b0;
    logic         sys_ren = 1'b0;
    logic [31:0]  sys_rdata;
    logic         sys_err;
    logic         sys_ack;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_sel;
    logic [7:0]   slv_wen;
    logic [7:0]   slv_ren;
    logic [255:0] slv_rdata = '0;
    logic [7:0]   slv_err = '0;
    logic [7:0]   slv_ack = '0;

    int checks = 0;
    int errors = 0;

    sys_bus_interconnect #(
        .SYS_AW(32), .SYS_DW(32), .SYS_SW(4), .NUM_SLV(8),
        .SLV_SHIFT(20), .SLV_EN(8'h7F), .TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
        .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
        .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack),
        .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata), .slv_sel_o(slv_sel),
        .slv_wen_o(slv_wen), .slv_ren_o(slv_ren),
        .slv_rdata_i(slv_rdata), .slv_err_i(slv_err), .slv_ack_i(slv_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] data;       // read data presented by the target slave
        int          ack_cyc;    // cycle in which ack_mask is driven (0 = never)
        logic [7:0]  ack_mask;
        logic [7:0]  err_mask;
        int          stray_cyc;  // extra late ack (0 = none)
        logic [7:0]  exp_wen;
        logic [7:0]  exp_ren;
        int          exp_ack_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Non-target slaves present 0x11111111*n so a wrong mux selection is visible.
    task automatic set_slave_data(input int tgt, input logic [31:0] data);
        for (int n = 0; n < 8; n++) begin
            slv_rdata[n*32 +: 32] = (n == tgt) ? data : (32'h1111_1111 * n);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          tgt;
        int          first_ack;
        int          npulse;
        logic [7:0]  w1, r1, extra;
        logic [31:0] rd;
        logic        er;
        tgt       = int'(v.addr[22:20]);
        first_ack = 0;
        npulse    = 0;
        extra     = '0;
        w1 = '0; r1 = '0; rd = '0; er = 1'b0;
        set_slave_data(tgt, v.data);
        @(negedge clk);
        sys_addr  = v.addr;
        sys_wdata = v.wdata;
        sys_sel   = v.sel;
        sys_wen   = v.wen;
        sys_ren   = v.ren;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            sys_wen = 1'b0;
            sys_ren = 1'b0;
            if (c == 1) begin
                w1 = slv_wen;
                r1 = slv_ren;
                chk({v.name, ".slv_addr"},  slv_addr,  v.addr & 32'h000F_FFFF);
                chk({v.name, ".slv_wdata"}, slv_wdata, v.wdata);
                chk({v.name, ".slv_sel"},   32'(slv_sel), 32'(v.sel));
            end else begin
                extra |= slv_wen | slv_ren;
            end
            if (sys_ack) begin
                npulse++;
                if (first_ack == 0) begin
                    first_ack = c;
                    rd = sys_rdata;
                    er = sys_err;
                end
            end
            if (c == v.ack_cyc || c == v.stray_cyc) begin
                slv_ack = v.ack_mask;
                slv_err = v.err_mask;
            end else begin
                slv_ack = '0;
                slv_err = '0;
            end
        end
        slv_ack = '0;
        slv_err = '0;
        chk({v.name, ".wen_c1"},    32'(w1), 32'(v.exp_wen));
        chk({v.name, ".ren_c1"},    32'(r1), 32'(v.exp_ren));
        chk({v.name, ".strobe_late"}, 32'(extra), 32'd0);
        chk({v.name, ".ack_cycle"}, 32'(first_ack), 32'(v.exp_ack_cyc));
        chk({v.name, ".ack_pulses"}, 32'(npulse), 32'd1);
        chk({v.name, ".rdata"},     rd, v.exp_rdata);
        chk({v.name, ".err"},       32'(er), 32'(v.exp_err));
        chk({v.name, ".rdata_hold"}, sys_rdata, v.exp_rdata);
        chk({v.name, ".err_hold"},  32'(sys_err), 32'(v.exp_err));
    endtask

    initial begin
        vecs[0] = '{name:"rd_s3", wen:1'b0, ren:1'b1, addr:32'h0030_0010, wdata:32'h0, sel:4'hF,
                    data:32'hDEAD_BEEF, ack_cyc:2, ack_mask:8'h08, err_mask:8'h00, stray_cyc:0,
                    exp_wen:8'h00, exp_ren:8'h08, exp_ack_cyc:3, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0};
        vecs[1] = '{name:"wr_s1", wen:1'b1, ren:1'b0, addr:32'h0010_0004, wdata:32'h1234_5678, sel:4'hF,
                    data:32'h9999_9999, ack_cyc:1, ack_mask:8'h02, err_mask:8'h00, stray_cyc:0,
                    exp_wen:8'h02, exp_ren:8'h00, exp_ack_cyc:2, exp_rdata:32'h0, exp_err:1'b0};
        vecs[2] = '{name:"rd_unpop7", wen:1'b0, ren:1'b1, addr:32'h0070_0000, wdata:32'h0, sel:4'hF,
                    data:32'h7777_7777, ack_cyc:0, ack_mask:8'h00, err_mask:8'h00, stray_cyc:0,
                    exp_wen:8'h00, exp_ren:8'h00, exp_ack_cyc:1, exp_rdata:32'h0, exp_err:1'b1};
        vecs[3] = '{name:"rd_silent5", wen:1'b0, ren:1'b1, addr:32'h0050_0100, wdata:32'h0, sel:4'hF,
                    data:32'h5555_AAAA, ack_cyc:0, ack_mask:8'h20, err_mask:8'h00, stray_cyc:20,
                    exp_wen:8'h00, exp_ren:8'h20, exp_ack_cyc:17, exp_rdata:32'h0, exp_err:1'b1};
        vecs[4] = '{name:"wen_ren_s4", wen:1'b1, ren:1'b1, addr:32'h0040_0008, wdata:32'hA5A5_0F0F, sel:4'h3,
                    data:32'h4444_CCCC, ack_cyc:2, ack_mask:8'h10, err_mask:8'h00, stray_cyc:0,
                    exp_wen:8'h10, exp_ren:8'h00, exp_ack_cyc:3, exp_rdata:32'h0, exp_err:1'b0};
        vecs[5] = '{name:"dual_ack_s3", wen:1'b0, ren:1'b1, addr:32'h0030_0FFC, wdata:32'h0, sel:4'hC,
                    data:32'h33C0_FFEE, ack_cyc:2, ack_mask:8'h0C, err_mask:8'h04, stray_cyc:0,
                    exp_wen:8'h00, exp_ren:8'h08, exp_ack_cyc:3, exp_rdata:32'h33C0_FFEE, exp_err:1'b0};
        vecs[6] = '{name:"ack_at_to_s6", wen:1'b0, ren:1'b1, addr:32'h0060_0020, wdata:32'h0, sel:4'hF,
                    data:32'h6060_6060, ack_cyc:16, ack_mask:8'h40, err_mask:8'h00, stray_cyc:0,
                    exp_wen:8'h00, exp_ren:8'h40, exp_ack_cyc:17, exp_rdata:32'h6060_6060, exp_err:1'b0};
        vecs[7] = '{name:"other_ack_s0", wen:1'b0, ren:1'b1, addr:32'h0000_0020, wdata:32'h0, sel:4'hF,
                    data:32'h0BAD_0BAD, ack_cyc:2, ack_mask:8'h02, err_mask:8'h02, stray_cyc:0,
                    exp_wen:8'h00, exp_ren:8'h01, exp_ack_cyc:17, exp_rdata:32'h0, exp_err:1'b1};
        vecs[8] = '{name:"err_ack_s4", wen:1'b0, ren:1'b1, addr:32'h0040_0ABC, wdata:32'h0, sel:4'h1,
                    data:32'hCAFE_F00D, ack_cyc:3, ack_mask:8'h10, err_mask:8'h10, stray_cyc:0,
                    exp_wen:8'h00, exp_ren:8'h10, exp_ack_cyc:4, exp_rdata:32'hCAFE_F00D, exp_err:1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.ack",   32'(sys_ack), 32'd0);
        chk("reset.rdata", sys_rdata, 32'd0);
        chk("reset.err",   32'(sys_err), 32'd0);
        chk("reset.strb",  32'({slv_wen, slv_ren}), 32'd0);
        chk("reset.addr",  slv_addr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Request during BUSY is ignored; back-to-back request in the ack cycle.
        set_slave_data(1, 32'h5A5A_5A5A);
        @(negedge clk);
        sys_addr = 32'h0010_0040; sys_wdata = 32'h0; sys_sel = 4'hF; sys_ren = 1'b1;
        @(posedge clk);
        @(negedge clk);                                   // cycle 1
        sys_ren = 1'b0;
        chk("busy.ren_c1", 32'(slv_ren), 32'h02);
        @(negedge clk);                                   // cycle 2
        sys_addr = 32'h0020_0000; sys_wdata = 32'hFFFF_0000; sys_wen = 1'b1;
        @(negedge clk);                                   // cycle 3
        sys_wen = 1'b0;
        chk("busy.no_fwd_wen", 32'(slv_wen), 32'h00);
        chk("busy.addr_held",  slv_addr, 32'h0000_0040);
        chk("busy.wdata_held", slv_wdata, 32'h0);
        slv_ack = 8'h02;
        @(negedge clk);                                   // cycle 4
        slv_ack = 8'h00;
        chk("busy.ack",   32'(sys_ack), 32'd1);
        chk("busy.rdata", sys_rdata, 32'h5A5A_5A5A);
        set_slave_data(2, 32'h2BAC_2BAC);
        sys_addr = 32'h0020_0008; sys_ren = 1'b1;
        @(negedge clk);                                   // cycle 5
        sys_ren = 1'b0;
        chk("b2b.ren",      32'(slv_ren), 32'h04);
        chk("b2b.ack_low",  32'(sys_ack), 32'd0);
        chk("b2b.addr",     slv_addr, 32'h0000_0008);
        slv_ack = 8'h04;
        @(negedge clk);                                   // cycle 6
        slv_ack = 8'h00;
        chk("b2b.ack",   32'(sys_ack), 32'd1);
        chk("b2b.rdata", sys_rdata, 32'h2BAC_2BAC);

        // Reset while the strobe is pending, then a stray ack after release.
        set_slave_data(3, 32'hDEAD_BEEF);
        @(negedge clk);
        sys_addr = 32'h0030_0004; sys_ren = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sys_ren = 1'b0;
        chk("rst_mid.ren_c1", 32'(slv_ren), 32'h08);
        rstn = 1'b0;
        #1;
        chk("rst_mid.ren",   32'(slv_ren), 32'h00);
        chk("rst_mid.rdata", sys_rdata, 32'h0);
        chk("rst_mid.ack",   32'(sys_ack), 32'd0);
        chk("rst_mid.addr",  slv_addr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        slv_ack = 8'h08;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                slv_ack = 8'h00;
                if (sys_ack) seen++;
            end
            chk("rst_mid.no_ack", 32'(seen), 32'd0);
        end
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
